// File: rtl/sram_responder.sv
// Behavioural async-style SRAM responder: byte-lane writes, pipelined lane-masked reads,
// saturating transaction counters and a sticky flag for read-drive/write overlap.
module sram_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        conflict
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              ub_n;
        logic              lb_n;
    } token_t;

    logic [15:0] mem_q [DEPTH];
    token_t      pipe_q [READ_LAT];
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;
    logic        conflict_q;

    logic              is_write;
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    token_t            new_tok;
    token_t            exit_tok;
    logic [15:0]       rd_word;
    logic              drive_hi;
    logic              drive_lo;
    logic              unused_addr;

    // Upper address bits alias onto the decoded range.
    assign addr        = SRAM_ADDR[ADDR_W-1:0];
    assign unused_addr = ^SRAM_ADDR;

    always_comb begin
        is_write       = !SRAM_CE_N && !SRAM_WE_N;
        is_read        = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
        new_tok        = '0;
        new_tok.valid  = is_read;
        new_tok.addr   = addr;
        new_tok.ub_n   = SRAM_UB_N;
        new_tok.lb_n   = SRAM_LB_N;
    end

    // Data is fetched when the token exits so writes issued while it was in flight are seen.
    always_comb begin
        exit_tok = pipe_q[READ_LAT-1];
        rd_word  = mem_q[exit_tok.addr];
        drive_hi = exit_tok.valid && !exit_tok.ub_n;
        drive_lo = exit_tok.valid && !exit_tok.lb_n;
    end

    assign SRAM_DQ[15:8] = drive_hi ? rd_word[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = drive_lo ? rd_word[7:0]  : 8'hzz;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= new_tok;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (is_write) begin
            if (!SRAM_LB_N) mem_q[addr][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) mem_q[addr][15:8] <= SRAM_DQ[15:8];
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_count_q <= 16'h0000;
            rd_count_q <= 16'h0000;
            conflict_q <= 1'b0;
        end else begin
            if (is_write && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            if (is_read && rd_count_q != 16'hFFFF)  rd_count_q <= rd_count_q + 16'd1;
            if (is_write && exit_tok.valid)         conflict_q <= 1'b1;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
    assign conflict = conflict_q;

endmodule
